// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle between the hazard unit and the datapath.
// master: hazard unit (drives stall/flush/ack); slave: datapath (drives hazard sources).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdE;
  logic             MemReadE;
  logic             PCSrcE;
  logic             MultiStartE;
  logic             MultiDoneE;
  logic             ExtStallReq;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             MultiAckE;
  logic             BusyTimeout;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    input  Rs1D, Rs2D, RdE, MemReadE, PCSrcE, MultiStartE, MultiDoneE, ExtStallReq,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, MultiAckE,
    output BusyTimeout, StallCount, FlushCount
  );

  modport slave (
    output Rs1D, Rs2D, RdE, MemReadE, PCSrcE, MultiStartE, MultiDoneE, ExtStallReq,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, MultiAckE,
    input  BusyTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer: load-use stalls, branch flushes, memory-wait freezes and
// multi-cycle execute occupancy with a sticky busy-timeout watchdog.
// Optional macro HAZARD_PERF_CNT_EN enables the StallCount/FlushCount registers;
// otherwise both counter outputs are tied to 0.
module hazard_ctrl #(
  parameter int unsigned MAX_BUSY = 64,
  parameter int unsigned CNT_W    = 32
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.master hz
);

  localparam int unsigned BusyW = $clog2(MAX_BUSY + 1);
  localparam logic [BusyW-1:0] MaxBusyC = BusyW'(MAX_BUSY);

  typedef enum logic [1:0] {StIdle, StBusy, StDoneWait} state_e;

  state_e           state_q;
  logic [BusyW-1:0] busy_cnt_q;
  logic             busy_timeout_q;
  logic             load_use;
  logic             multi_block;
  logic             multi_ack;

  // Hazard detection: load-use match, multi-cycle blocking and result acknowledge.
  always_comb begin
    load_use = hz.MemReadE && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // A done pulse without a memory wait releases E that same cycle, so it does not block.
    multi_block = ((state_q == StIdle) && hz.MultiStartE && !hz.MultiDoneE) ||
                  ((state_q == StBusy) && !(hz.MultiDoneE && !hz.ExtStallReq)) ||
                  ((state_q == StDoneWait) && hz.ExtStallReq);
    multi_ack = !reset && !hz.ExtStallReq &&
                (((state_q == StIdle) && hz.MultiStartE && hz.MultiDoneE) ||
                 ((state_q == StBusy) && hz.MultiDoneE) ||
                 (state_q == StDoneWait));
  end

  // Prioritised stall/flush controls; reset forces everything low.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.MultiAckE = multi_ack;
    if (!reset) begin
      if (hz.ExtStallReq) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
      end else if (multi_block) begin
        // Hold F/D/E and feed a bubble into M while the unit is busy.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else if (hz.PCSrcE) begin
        // Squashed D instruction makes any load-use irrelevant.
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (load_use) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  // Multi-cycle occupancy FSM with saturating busy counter and sticky watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      busy_cnt_q     <= '0;
      busy_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hz.MultiStartE) begin
            if (!hz.MultiDoneE) begin
              state_q    <= StBusy;
              busy_cnt_q <= BusyW'(1);
            end else if (hz.ExtStallReq) begin
              state_q <= StDoneWait;
            end
          end
        end
        StBusy: begin
          if (hz.MultiDoneE) begin
            state_q    <= hz.ExtStallReq ? StDoneWait : StIdle;
            busy_cnt_q <= '0;
          end else if (busy_cnt_q != MaxBusyC) begin
            busy_cnt_q <= busy_cnt_q + BusyW'(1);
            // Flag as the count reaches its limit; the unit is left to finish.
            if (busy_cnt_q == MaxBusyC - BusyW'(1)) begin
              busy_timeout_q <= 1'b1;
            end
          end
        end
        StDoneWait: begin
          if (!hz.ExtStallReq) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hz.BusyTimeout = busy_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating performance counters for stalled-fetch and flushed-decode cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (hz.FlushD && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = '0;
  assign hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_BUSY=8, CNT_W=4).
module tb_hazard_ctrl;

  localparam int unsigned MaxBusy = 8;
  localparam int unsigned CntW    = 4;

  // Input flag bits: {MemReadE, PCSrcE, MultiStartE, MultiDoneE, ExtStallReq}
  localparam logic [4:0] FNone = 5'b00000;
  localparam logic [4:0] FMr   = 5'b10000;
  localparam logic [4:0] FPc   = 5'b01000;
  localparam logic [4:0] FMs   = 5'b00100;
  localparam logic [4:0] FMd   = 5'b00010;
  localparam logic [4:0] FEx   = 5'b00001;

  // Control bits: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, MultiAckE}
  localparam logic [7:0] CNone = 8'b0000_0000;
  localparam logic [7:0] CLu   = 8'b1100_0100;
  localparam logic [7:0] CBr   = 8'b0000_1100;
  localparam logic [7:0] CMb   = 8'b1110_0010;
  localparam logic [7:0] CEx   = 8'b1111_0000;
  localparam logic [7:0] CAck  = 8'b0000_0001;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   exp_sc;
  int   exp_fc;
  logic [7:0] ctl;

  hazard_ctrl_if #(.CNT_W(CntW)) hz_if ();

  hazard_ctrl #(
    .MAX_BUSY(MaxBusy),
    .CNT_W   (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM,
                hz_if.FlushD, hz_if.FlushE, hz_if.FlushM, hz_if.MultiAckE};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic drive(input logic [4:0] flags, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    {hz_if.MemReadE, hz_if.PCSrcE, hz_if.MultiStartE, hz_if.MultiDoneE, hz_if.ExtStallReq} = flags;
    hz_if.RdE  = rd;
    hz_if.Rs1D = rs1;
    hz_if.Rs2D = rs2;
  endtask

  // One cycle: drive just after the rising edge, check mid-cycle, advance past next edge.
  task automatic cyc(input string tag, input logic [4:0] flags, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [7:0] exp);
    drive(flags, rd, rs1, rs2);
    #3;
    check_val(tag, {24'd0, ctl}, {24'd0, exp});
    if (exp[7] && exp_sc < 15) exp_sc++;
    if (exp[3] && exp_fc < 15) exp_fc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check_val({tag, "_stall_cnt"}, {28'd0, hz_if.StallCount}, cnt_exp(exp_sc));
    check_val({tag, "_flush_cnt"}, {28'd0, hz_if.FlushCount}, cnt_exp(exp_fc));
  endtask

  task automatic do_reset(input string tag, input logic [4:0] flags);
    reset = 1'b1;
    drive(flags, 5'd5, 5'd5, 5'd0);
    #3;
    check_val({tag, "_ctl_in_reset"}, {24'd0, ctl}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    exp_sc = 0;
    exp_fc = 0;
    reset  = 1'b1;
    drive(FNone, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    // Reset must dominate active hazards and a memory wait.
    do_reset("rst0", FMr | FPc | FEx);
    check_val("rst_timeout", {31'd0, hz_if.BusyTimeout}, 32'd0);
    check_cnts("rst");

    // Load-use detection.
    cyc("lu_rs1",   FMr, 5'd5, 5'd5, 5'd9, CLu);
    cyc("lu_rd0",   FMr, 5'd0, 5'd0, 5'd0, CNone);
    cyc("lu_rs2",   FMr, 5'd7, 5'd1, 5'd7, CLu);
    cyc("no_load",  FNone, 5'd5, 5'd5, 5'd5, CNone);
    cyc("lu_miss",  FMr, 5'd5, 5'd6, 5'd7, CNone);

    // Taken branch overrides load-use.
    cyc("br_over_lu", FMr | FPc, 5'd5, 5'd5, 5'd0, CBr);
    check_cnts("after_br");

    // Multi-cycle op, done on the 4th cycle; branch ignored while blocked.
    cyc("mul_c1",   FMs, 5'd0, 5'd0, 5'd0, CMb);
    cyc("mul_c2pc", FMs | FPc, 5'd0, 5'd0, 5'd0, CMb);
    cyc("mul_c3",   FMs, 5'd0, 5'd0, 5'd0, CMb);
    cyc("mul_done", FMs | FMd, 5'd0, 5'd0, 5'd0, CAck);
    cyc("mul_idle", FNone, 5'd0, 5'd0, 5'd0, CNone);
    cyc("mul_fast", FMs | FMd, 5'd0, 5'd0, 5'd0, CAck);

    // Done arrives during a memory wait.
    cyc("dw_busy",  FMs, 5'd0, 5'd0, 5'd0, CMb);
    cyc("dw_done",  FMs | FMd | FEx, 5'd0, 5'd0, 5'd0, CEx);
    cyc("dw_wait",  FMs | FEx, 5'd0, 5'd0, 5'd0, CEx);
    cyc("dw_ack",   FMs, 5'd0, 5'd0, 5'd0, CAck);
    cyc("dw_idle",  FNone, 5'd0, 5'd0, 5'd0, CNone);
    cyc("ext_over", FMr | FPc | FEx, 5'd3, 5'd3, 5'd0, CEx);
    // Idle start+done under a memory wait, then ack alongside a branch flush.
    cyc("dw2_done", FMs | FMd | FEx, 5'd0, 5'd0, 5'd0, CEx);
    cyc("dw2_ack_br", FMs | FPc, 5'd0, 5'd0, 5'd0, CAck | CBr);
    check_cnts("after_multi");

    // Watchdog: timeout rises after the 8th blocked cycle and stays set.
    check_val("wd_pre", {31'd0, hz_if.BusyTimeout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc("wd_busy", FMs, 5'd0, 5'd0, 5'd0, CMb);
      if (i == 6) check_val("wd_7th", {31'd0, hz_if.BusyTimeout}, 32'd0);
    end
    check_val("wd_8th", {31'd0, hz_if.BusyTimeout}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("wd_hold", FMs, 5'd0, 5'd0, 5'd0, CMb);
    end
    check_val("wd_sticky", {31'd0, hz_if.BusyTimeout}, 32'd1);
    do_reset("rst1", FMs);
    check_val("rst1_timeout", {31'd0, hz_if.BusyTimeout}, 32'd0);
    check_cnts("rst1");
    cyc("rst1_idle", FNone, 5'd0, 5'd0, 5'd0, CNone);
    cyc("rst1_lu",   FMr, 5'd4, 5'd4, 5'd0, CLu);

    // Counter saturation with a held load-use.
    for (int i = 0; i < 20; i++) begin
      cyc("sat_lu", FMr, 5'd9, 5'd0, 5'd9, CLu);
    end
    check_val("sat_stall", {28'd0, hz_if.StallCount}, cnt_exp(15));
    check_cnts("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
